// File: rtl/wr_req_sequencer_pkg.sv
// Shared types and helpers for the write-request sequencer.
// Request descriptor, FSM state encoding, beat/chunk sizing and tkeep popcount.
// No logic of its own; imported by the sequencer and its chunk FIFO.
package wr_req_sequencer_pkg;

  localparam int WRQ_DATA_BITS  = 512;
  localparam int WRQ_VADDR_BITS = 48;
  localparam int WRQ_LEN_BITS   = 28;
  localparam int WRQ_XFER_BYTES = 4096;

  // Widest tkeep the popcount helper accepts (covers data paths up to 2048 bits).
  localparam int KEEP_MAX = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    REQ   = 2'd2,
    DRAIN = 2'd3
  } wrq_state_e;

  typedef struct packed {
    logic [WRQ_VADDR_BITS-1:0] vaddr;
    logic [WRQ_LEN_BITS-1:0]   len;
    logic                      last;
  } wr_req_t;

  function automatic int beat_bytes(input int data_bits);
    return data_bits / 8;
  endfunction

  function automatic int chunk_beats(input int xfer_bytes, input int data_bits);
    return xfer_bytes / (data_bits / 8);
  endfunction

  function automatic logic [15:0] popcount(input logic [KEEP_MAX-1:0] keep);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) n = n + {15'd0, keep[i]};
    return n;
  endfunction

endpackage

// File: rtl/wr_req_sequencer_chunk_fifo.sv
// Synchronous beat FIFO holding one chunk of {tdata, tkeep, tlast}.
// Latency: a pushed word is visible on o_pop_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; reset or flush empties it.
module wr_chunk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign o_pop_dat = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; reset and flush both discard all content.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/wr_req_sequencer.sv
// Chunks a packet stream into <=XFER_BYTES pieces, issues one write request per chunk, then releases its data.
// Latency: request 1 cycle after chunk close; first data beat 1 cycle after request handshake.
// Backpressure: input stalled outside FILL; req_ready and m_tready stall without loss. Optional stats: WR_REQ_SEQ_STATS_EN.
module wr_req_sequencer
  import wr_req_sequencer_pkg::*;
#(
  parameter int DATA_BITS  = WRQ_DATA_BITS,
  parameter int VADDR_BITS = WRQ_VADDR_BITS,
  parameter int LEN_BITS   = WRQ_LEN_BITS,
  parameter int XFER_BYTES = WRQ_XFER_BYTES
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    i_start,
  input  logic [VADDR_BITS-1:0]   i_vaddr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [31:0]             o_bytes,
  input  logic [DATA_BITS-1:0]    s_tdata,
  input  logic [DATA_BITS/8-1:0]  s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [VADDR_BITS-1:0]   req_vaddr,
  output logic [LEN_BITS-1:0]     req_len,
  output logic                    req_last,
  output logic [DATA_BITS-1:0]    m_tdata,
  output logic [DATA_BITS/8-1:0]  m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready
`ifdef WR_REQ_SEQ_STATS_EN
  ,
  output logic [31:0]             o_req_cnt,
  output logic [31:0]             o_stall_cnt
`endif
);

  localparam int KEEP_BITS   = beat_bytes(DATA_BITS);
  localparam int CHUNK_BEATS = chunk_beats(XFER_BYTES, DATA_BITS);
  localparam int CNT_W       = $clog2(CHUNK_BEATS + 1);
  localparam int FIFO_W      = DATA_BITS + KEEP_BITS + 1;

  wrq_state_e            r_state;
  wrq_state_e            w_state_nxt;
  logic [VADDR_BITS-1:0] r_cur_vaddr;
  logic [LEN_BITS-1:0]   r_chunk_bytes;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic                  r_pkt_last;
  logic                  r_busy;
  logic                  r_done;
  logic [31:0]           r_bytes;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_in_hs;
  logic                  w_req_hs;
  logic                  w_pop;
  logic                  w_empty_pkt;
  logic                  w_drain_end;
  logic [LEN_BITS-1:0]   w_chunk_bytes_nxt;
  logic [FIFO_W-1:0]     w_pop_dat;
  logic [DATA_BITS-1:0]  w_pop_tdata;
  logic [KEEP_BITS-1:0]  w_pop_tkeep;
  logic                  w_unused_tlast;
  wr_req_t               w_req;

  assign s_tready  = (r_state == FILL) && !w_full;
  assign req_valid = (r_state == REQ);
  assign m_tvalid  = (r_state == DRAIN) && !w_empty;
  assign w_in_hs   = s_tvalid & s_tready;
  assign w_req_hs  = req_valid & req_ready;
  assign w_pop     = m_tvalid & m_tready;

  assign w_chunk_bytes_nxt = r_chunk_bytes + LEN_BITS'(popcount(KEEP_MAX'(s_tkeep)));

  // Request fields come straight from registers, so they hold steady while req_ready is low.
  assign w_req     = '{vaddr: r_cur_vaddr, len: r_chunk_bytes, last: r_pkt_last};
  assign req_vaddr = w_req.vaddr;
  assign req_len   = w_req.len;
  assign req_last  = w_req.last;

  // The stored tlast is informational only: m_tlast marks chunk ends, not packet ends.
  assign {w_pop_tdata, w_pop_tkeep, w_unused_tlast} = w_pop_dat;
  assign m_tdata = m_tvalid ? w_pop_tdata : '0;
  assign m_tkeep = m_tvalid ? w_pop_tkeep : '0;
  assign m_tlast = m_tvalid && (r_beat_cnt == CNT_W'(1));

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_bytes = r_bytes;

  wr_chunk_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (CHUNK_BEATS)
  ) u_fifo (
    .i_clk      (aclk),
    .i_rst      (areset),
    .i_flush    (w_empty_pkt),
    .i_push     (w_in_hs),
    .i_push_dat ({s_tdata, s_tkeep, s_tlast}),
    .i_pop      (w_pop),
    .o_pop_dat  (w_pop_dat),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Next-state decode: close chunks on count or tlast, drop byte-less final chunks.
  always_comb begin
    w_state_nxt = r_state;
    w_empty_pkt = 1'b0;
    w_drain_end = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = FILL;
      FILL: begin
        if (w_in_hs && ((r_beat_cnt == CNT_W'(CHUNK_BEATS - 1)) || s_tlast)) begin
          if (s_tlast && (w_chunk_bytes_nxt == '0)) begin
            w_empty_pkt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      REQ: if (w_req_hs) w_state_nxt = DRAIN;
      DRAIN: begin
        if (w_pop && (r_beat_cnt == CNT_W'(1))) begin
          w_drain_end = 1'b1;
          w_state_nxt = r_pkt_last ? IDLE : FILL;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Chunk accounting, address advance and packet status.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cur_vaddr   <= '0;
      r_chunk_bytes <= '0;
      r_beat_cnt    <= '0;
      r_pkt_last    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_bytes       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cur_vaddr   <= i_vaddr;
            r_bytes       <= '0;
            r_busy        <= 1'b1;
            r_chunk_bytes <= '0;
            r_beat_cnt    <= '0;
            r_pkt_last    <= 1'b0;
          end
        end
        FILL: begin
          if (w_empty_pkt) begin
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_chunk_bytes <= '0;
            r_beat_cnt    <= '0;
            r_pkt_last    <= 1'b0;
          end else if (w_in_hs) begin
            r_chunk_bytes <= w_chunk_bytes_nxt;
            r_beat_cnt    <= r_beat_cnt + CNT_W'(1);
            r_pkt_last    <= s_tlast;
          end
        end
        REQ: begin
          if (w_req_hs) begin
            r_cur_vaddr <= r_cur_vaddr + VADDR_BITS'(r_chunk_bytes);
            r_bytes     <= r_bytes + 32'(r_chunk_bytes);
          end
        end
        DRAIN: begin
          if (w_pop) begin
            r_beat_cnt <= r_beat_cnt - CNT_W'(1);
            if (w_drain_end) begin
              r_chunk_bytes <= '0;
              if (r_pkt_last) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WR_REQ_SEQ_STATS_EN
  logic [31:0] r_req_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall     = (req_valid & ~req_ready) | (m_tvalid & ~m_tready);
  assign o_req_cnt   = r_req_cnt;
  assign o_stall_cnt = r_stall_cnt;

  // Saturating request and stall counters, cleared only by reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_req_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_req_hs && (r_req_cnt != '1))   r_req_cnt   <= r_req_cnt + 32'd1;
      if (w_stall && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wr_req_sequencer.sv
module tb_wr_req_sequencer;

  localparam int DATA_BITS  = 512;
  localparam int VADDR_BITS = 48;
  localparam int LEN_BITS   = 28;
  localparam int KEEP_BITS  = DATA_BITS / 8;

  logic                  aclk;
  logic                  areset;
  logic                  i_start;
  logic [VADDR_BITS-1:0] i_vaddr;
  logic                  o_busy;
  logic                  o_done;
  logic [31:0]           o_bytes;
  logic [DATA_BITS-1:0]  s_tdata;
  logic [KEEP_BITS-1:0]  s_tkeep;
  logic                  s_tlast;
  logic                  s_tvalid;
  logic                  s_tready;
  logic                  req_valid;
  logic                  req_ready;
  logic [VADDR_BITS-1:0] req_vaddr;
  logic [LEN_BITS-1:0]   req_len;
  logic                  req_last;
  logic [DATA_BITS-1:0]  m_tdata;
  logic [KEEP_BITS-1:0]  m_tkeep;
  logic                  m_tlast;
  logic                  m_tvalid;
  logic                  m_tready;
`ifdef WR_REQ_SEQ_STATS_EN
  logic [31:0]           o_req_cnt;
  logic [31:0]           o_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  logic [DATA_BITS-1:0] q_dat  [$];
  logic [KEEP_BITS-1:0] q_keep [$];

  localparam logic [KEEP_BITS-1:0] KEEP_ALL = '1;

  wr_req_sequencer dut (
    .aclk      (aclk),
    .areset    (areset),
    .i_start   (i_start),
    .i_vaddr   (i_vaddr),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_bytes   (o_bytes),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vaddr (req_vaddr),
    .req_len   (req_len),
    .req_last  (req_last),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
`ifdef WR_REQ_SEQ_STATS_EN
    ,
    .o_req_cnt   (o_req_cnt),
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DATA_BITS-1:0] obs, input logic [DATA_BITS-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_BITS-1:0] mk(input int s);
    logic [31:0] w;
    w = s ^ 32'hA5A5_0000;
    return {16{w}};
  endfunction

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic send_beat(input logic [DATA_BITS-1:0] d, input logic [KEEP_BITS-1:0] k, input logic l);
    int n;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 200) begin @(negedge aclk); n++; end
    chk("s_tready_seen", 64'(s_tready), 64'd1);
    @(negedge aclk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    q_dat.push_back(d);
    q_keep.push_back(k);
  endtask

  task automatic send_full(input int cnt, input logic last_on_final);
    for (int i = 0; i < cnt; i++) begin
      send_beat(mk(seq), KEEP_ALL, last_on_final && (i == cnt - 1));
      seq++;
    end
  endtask

  task automatic start(input logic [VADDR_BITS-1:0] v);
    i_vaddr = v; i_start = 1'b1;
    @(negedge aclk);
    i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
  endtask

  task automatic take_req(input logic [63:0] v, input logic [63:0] len, input logic last, input int hold);
    int n;
    n = 0;
    while (!req_valid && n < 200) begin @(negedge aclk); n++; end
    chk("req_valid_seen", 64'(req_valid), 64'd1);
    chk("req_vaddr", 64'(req_vaddr), v);
    chk("req_len", 64'(req_len), len);
    chk("req_last", 64'(req_last), 64'(last));
    for (int i = 0; i < hold; i++) begin
      chk("hold_req_valid", 64'(req_valid), 64'd1);
      chk("hold_req_vaddr", 64'(req_vaddr), v);
      chk("hold_req_len", 64'(req_len), len);
      chk("hold_s_tready", 64'(s_tready), 64'd0);
      @(negedge aclk);
    end
    req_ready = 1'b1;
    @(negedge aclk);
    req_ready = 1'b0;
  endtask

  // Accept n beats; m_tlast expected only on beat index last_at-1 of this chunk.
  task automatic drain(input int n, input int last_at, input logic toggle);
    int got;
    int cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < 1000) begin
      m_tready = toggle ? cyc[0] : 1'b1;
      if (m_tvalid && m_tready) begin
        chkw("m_tdata", m_tdata, q_dat[0]);
        chk("m_tkeep", 64'(m_tkeep), 64'(q_keep[0]));
        chk("m_tlast", 64'(m_tlast), 64'(got == last_at - 1));
        chk("s_tready_in_drain", 64'(s_tready), 64'd0);
        void'(q_dat.pop_front());
        void'(q_keep.pop_front());
        got++;
      end
      @(negedge aclk);
      cyc++;
    end
    m_tready = 1'b0;
    chk("drain_count", 64'(got), 64'(n));
  endtask

  task automatic chk_done(input logic [31:0] bytes);
    chk("done_pulse", 64'(o_done), 64'd1);
    chk("busy_clear", 64'(o_busy), 64'd0);
    chk("o_bytes", 64'(o_bytes), 64'(bytes));
    @(negedge aclk);
    chk("done_one_cycle", 64'(o_done), 64'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_bytes"}, 64'(o_bytes), 64'd0);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({tag, "_req"}, {15'd0, req_valid, req_last, req_vaddr}, 64'd0);
    chk({tag, "_req_len"}, 64'(req_len), 64'd0);
    chk({tag, "_m_ctl"}, {m_tvalid, m_tlast, m_tkeep[61:0]}, 64'd0);
    chkw({tag, "_m_tdata"}, m_tdata, '0);
  endtask

  initial begin
    areset = 1'b1; i_start = 1'b0; i_vaddr = '0;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    req_ready = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk_idle_outputs("reset");
`ifdef WR_REQ_SEQ_STATS_EN
    chk("reset_req_cnt", 64'(o_req_cnt), 64'd0);
    chk("reset_stall_cnt", 64'(o_stall_cnt), 64'd0);
`endif

    // Short packet: 3 full beats + 16-byte tail; a stray start mid-fill is ignored.
    start(48'h1000);
    send_full(1, 1'b0);
    i_vaddr = 48'h9000; i_start = 1'b1;
    @(negedge aclk);
    i_start = 1'b0;
    send_full(2, 1'b0);
    send_beat(mk(seq), 64'h0000_0000_0000_FFFF, 1'b1); seq++;
    take_req(64'h1000, 64'd208, 1'b1, 0);
    drain(4, 4, 1'b0);
    chk_done(32'd208);

    // 130 beats: two full chunks then a 2-beat tail.
    start(48'h0);
    send_full(64, 1'b0);
    take_req(64'h0, 64'd4096, 1'b0, 0);
    drain(64, 64, 1'b0);
    chk("mid_pkt_busy", 64'(o_busy), 64'd1);
    chk("mid_pkt_done", 64'(o_done), 64'd0);
    send_full(64, 1'b0);
    take_req(64'h1000, 64'd4096, 1'b0, 0);
    drain(64, 64, 1'b0);
    send_full(2, 1'b1);
    take_req(64'h2000, 64'd128, 1'b1, 0);
    drain(2, 2, 1'b0);
    chk_done(32'd8320);

    // tlast on exactly the 64th beat: one request, no trailing empty chunk.
    start(48'h7000);
    send_full(64, 1'b1);
    take_req(64'h7000, 64'd4096, 1'b1, 0);
    drain(64, 64, 1'b0);
    chk_done(32'd4096);
    for (int i = 0; i < 5; i++) begin
      chk("no_extra_req", 64'(req_valid), 64'd0);
      chk("idle_s_tready", 64'(s_tready), 64'd0);
      @(negedge aclk);
    end

    // Lone zero-keep tlast beat: no request, done pulse, back to idle.
    start(48'h8000);
    send_beat(mk(seq), '0, 1'b1); seq++;
    q_dat.delete(); q_keep.delete();
    chk("empty_req_valid", 64'(req_valid), 64'd0);
    chk_done(32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("empty_no_req", 64'(req_valid), 64'd0);
      chk("empty_no_data", 64'(m_tvalid), 64'd0);
      @(negedge aclk);
    end

    // Request held off 20 cycles, then output ready toggling every cycle.
    start(48'h3000);
    send_full(1, 1'b0);
    send_beat(mk(seq), 64'hFF, 1'b1); seq++;
    take_req(64'h3000, 64'd72, 1'b1, 20);
    drain(2, 2, 1'b1);
    chk_done(32'd72);
`ifdef WR_REQ_SEQ_STATS_EN
    chk("stats_req_cnt", 64'(o_req_cnt), 64'd6);
    chk("stats_stall_cnt", 64'(o_stall_cnt), 64'd22);
`endif

    // Start coincident with reset: reset wins.
    areset = 1'b1; i_start = 1'b1; i_vaddr = 48'hDEAD;
    @(negedge aclk);
    areset = 1'b0; i_start = 1'b0;
    @(negedge aclk);
    chk_idle_outputs("rst_start");
`ifdef WR_REQ_SEQ_STATS_EN
    chk("rst_req_cnt", 64'(o_req_cnt), 64'd0);
`endif

    // Reset mid-drain, then a fresh single-beat packet.
    start(48'h4000);
    send_full(3, 1'b1);
    take_req(64'h4000, 64'd192, 1'b1, 0);
    drain(1, 3, 1'b0);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    chk_idle_outputs("rst_drain");
    q_dat.delete(); q_keep.delete();
    start(48'h5000);
    send_full(1, 1'b1);
    take_req(64'h5000, 64'd64, 1'b1, 0);
    drain(1, 1, 1'b0);
    chk_done(32'd64);
    for (int i = 0; i < 4; i++) begin
      m_tready = 1'b1;
      chk("no_stale_beats", 64'(m_tvalid), 64'd0);
      @(negedge aclk);
    end
    m_tready = 1'b0;
`ifdef WR_REQ_SEQ_STATS_EN
    chk("final_req_cnt", 64'(o_req_cnt), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
